// File: rtl/sar_search_4bit_pkg.sv
// rtl/sar_search_4bit_pkg.sv - shared types and constants for the 4-bit SAR search
package sar_pkg;

  localparam int W = 4;
  localparam logic [W-1:0] PROBE_INIT = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // A comparator answer is trustworthy only when exactly one flag is raised.
  function automatic logic is_one_hot(input logic gt, input logic eq, input logic lt);
    logic ok;
    case ({gt, eq, lt})
      3'b100, 3'b010, 3'b001: ok = 1'b1;
      default:                ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/sar_search_4bit_if.sv
// rtl/sar_search_4bit_if.sv - control, comparator and result signals of the SAR search
interface sar_search_4bit_if;
  import sar_pkg::*;

  logic           start;
  logic           a_gt_b;
  logic           a_eq_b;
  logic           a_lt_b;
  logic [W-1:0]   probe;
  logic           busy;
  logic           done;
  logic [W-1:0]   result;
  logic           err;
  logic [2:0]     cmp_count;

  // Requester side: launches searches and supplies comparator flags.
  modport master (
    output start, a_gt_b, a_eq_b, a_lt_b,
    input  probe, busy, done, result, err, cmp_count
  );

  // Search engine side.
  modport slave (
    input  start, a_gt_b, a_eq_b, a_lt_b,
    output probe, busy, done, result, err, cmp_count
  );

endinterface

// File: rtl/sar_search_4bit.sv
// rtl/sar_search_4bit.sv - successive-approximation search for a hidden 4-bit target
module sar_search_4bit
  import sar_pkg::*;
#(
  parameter int CMP_LAT = 1
) (
  input logic           clk,
  input logic           rst,
  sar_search_4bit_if.slave bus
);

  localparam logic [3:0] LAT = 4'(CMP_LAT);

  state_t       state;
  state_t       state_next;
  logic [W-1:0] probe_q;
  logic [W-1:0] result_q;
  logic [1:0]   index_q;
  logic [3:0]   wait_q;
  logic         err_q;
  logic [2:0]   cmp_count_q;

  logic         flags_ok;
  logic         sample;
  logic         finish;
  logic [W-1:0] probe_cleared;
  logic [W-1:0] probe_advanced;
  logic         busy;
  logic         done;

  // Decide what the current flag sample means for the probe.
  always_comb begin
    flags_ok       = is_one_hot(bus.a_gt_b, bus.a_eq_b, bus.a_lt_b);
    sample         = (state == ST_WAIT) && (wait_q <= 4'd1);
    probe_cleared  = probe_q;
    if (bus.a_lt_b) begin
      probe_cleared[index_q] = 1'b0;
    end
    probe_advanced = probe_cleared;
    probe_advanced[index_q - 2'd1] = 1'b1;
    finish         = sample && (!flags_ok || bus.a_eq_b || (index_q == 2'd0));
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; start is only looked at in IDLE.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (bus.start) state_next = ST_WAIT;
      ST_WAIT: if (finish)    state_next = ST_DONE;
      ST_DONE:                state_next = ST_IDLE;
      default:                state_next = ST_IDLE;
    endcase
  end

  // Status outputs decoded from the state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      ST_WAIT: busy = 1'b1;
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // Probe, settle counter and result bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      probe_q     <= '0;
      result_q    <= '0;
      index_q     <= 2'd3;
      wait_q      <= 4'd0;
      err_q       <= 1'b0;
      cmp_count_q <= 3'd0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (bus.start) begin
            probe_q     <= PROBE_INIT;
            index_q     <= 2'd3;
            wait_q      <= LAT;
            err_q       <= 1'b0;
            cmp_count_q <= 3'd0;
          end
        end
        ST_WAIT: begin
          if (sample) begin
            cmp_count_q <= cmp_count_q + 3'd1;
            if (!flags_ok) begin
              err_q    <= 1'b1;
              result_q <= probe_q;
            end else if (bus.a_eq_b) begin
              result_q <= probe_q;
            end else if (index_q == 2'd0) begin
              probe_q  <= probe_cleared;
              result_q <= probe_cleared;
            end else begin
              probe_q <= probe_advanced;
              index_q <= index_q - 2'd1;
              wait_q  <= LAT;
            end
          end else begin
            wait_q <= wait_q - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.probe     = probe_q;
  assign bus.result    = result_q;
  assign bus.err       = err_q;
  assign bus.cmp_count = cmp_count_q;
  assign bus.busy      = busy;
  assign bus.done      = done;

endmodule

// File: doc/sar_search_4bit.md
SAR_SEARCH_4BIT -- requirements
Module: sar_search_4bit

Interface
REQ-001 SHALL have parameter CMP_LAT, default 1, meaning the number of cycles the probe is held stable before the flags are sampled; legal range 1..15.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port start  input  1  request to begin a search; sampled only in IDLE.
REQ-005 SHALL have port a_gt_b  input  1  comparator flag: hidden target greater than probe.
REQ-006 SHALL have port a_eq_b  input  1  comparator flag: target equal to probe.
REQ-007 SHALL have port a_lt_b  input  1  comparator flag: target less than probe.
REQ-008 SHALL have port probe  output  4  value driven to the comparator b operand.
REQ-009 SHALL have port busy  output  1  high while a search is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse when result is valid.
REQ-011 SHALL have port result  output  4  value found; held until the next accepted start.
REQ-012 SHALL have port err  output  1  set when the flags sampled at any step were not exactly one-hot; held like result.
REQ-013 SHALL have port cmp_count  output  3  number of flag samples used (1..4); held like result.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT and DONE.
REQ-015 SHALL, in IDLE with start=1 at edge E0: set probe=4'b1000, bit index=3, wait counter=CMP_LAT, busy=1, clear err and cmp_count, and go to WAIT.
REQ-016 SHALL hold probe constant in WAIT and decrement the counter each cycle.
REQ-017 SHALL sample the flags on the edge where the counter expires; step k is sampled at E0+k*CMP_LAT.
REQ-018 SHALL increment cmp_count at every sample.
REQ-019 SHALL, at a sample, apply the first matching rule:
  - flags not one-hot -> err=1, result=probe, go to DONE;
  - a_eq_b -> result=probe, go to DONE;
  - a_lt_b -> clear probe[index];
  - a_gt_b -> keep probe[index].
REQ-020 SHALL, after a gt/lt decision: if index=0, set result to the updated probe and go to DONE; else set probe[index-1]=1, decrement index, reload counter=CMP_LAT, and stay in WAIT.
REQ-021 SHALL, in DONE: assert done=1 and busy=0 for exactly one cycle, then return to IDLE.
REQ-022 SHALL have a worst-case latency of done high in the cycle after edge E0+4*CMP_LAT.
REQ-023 SHALL ignore start while busy or in DONE; start held high SHALL launch a new search only on the first edge back in IDLE.
REQ-024 SHALL keep probe at its final value after DONE until the next accepted start.
REQ-025 SHALL resolve every target 0..15 in at most 4 samples; target 0 terminates by four lt decisions with no eq.

Reset
REQ-026 SHALL, on rst=1 and independent of clk: state=IDLE, probe=0, busy=0, done=0, result=0, err=0, cmp_count=0, index=3, counter=0.
REQ-027 SHALL abort any search in progress on reset mid-operation, with no done pulse.
REQ-028 SHALL accept start on the first rising edge after rst deasserts.

Structure
REQ-029 SHALL place the state enum, the width constant W=4 and the initial probe constant 4'b1000 in a shared package, sar_pkg.
REQ-030 SHALL contain no sub-module; the bench instantiates comparator_4bit (a=target, b=probe) plus CMP_LAT-1 register stages as the flag source.

Verification
REQ-031 SHALL cover: CMP_LAT=1, target=15 -> probes 8,12,14,15; eq at step 4; result=15, cmp_count=4, err=0; done in the cycle after E0+4.
REQ-032 SHALL cover: target=0 -> probes 8,4,2,1, all lt; result=0, cmp_count=4, err=0.
REQ-033 SHALL cover: target=8 -> eq at the first sample; result=8, cmp_count=1; done in the cycle after E0+1.
REQ-034 SHALL cover: CMP_LAT=3, target=5, start held high throughout -> probes 8,4,6,5, each held 3 cycles; result=5, cmp_count=4; no restart until back in IDLE.
REQ-035 SHALL cover: forcing a_gt_b=a_lt_b=1 at the first sample -> err=1, result=8, cmp_count=1, done pulses once.
REQ-036 SHALL cover: rst pulsed after the 2nd sample -> all outputs zero with no done; a following search for target=9 -> result=9.
